seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector. It captures a parallel word on a start pulse and shifts it out MSB-first, one bit per clock, into a sliding match window. It reports whether a programmable pattern occurred, how many times, and where it first ended. It is the generalised successor of the board-level fixed-pattern switch detector, and it sits between the debounced button/switch inputs and the status LEDs/display.

## Interface
Parameters:
- DATA_W, 8: width of the captured word; number of bits scanned per run (≥ 2).
- PAT_W, 5: pattern length in bits (1 ≤ PAT_W ≤ DATA_W).
- PATTERN, 5'b10010: pattern to detect; bit PAT_W-1 is the earliest bit in time.
- OVERLAP, 1: 1 = overlapping matches counted; 0 = after a hit, the window must refill completely.
- CNT_W, 4: width of the match counter (saturating).
- POS_W, $clog2(DATA_W): width of the position output.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- button  in  1  start pulse (synchronous, already debounced, one cycle per press).
- switch  in  DATA_W  word to scan, sampled only on the edge where button=1.
- busy  out  1  high while bits are being scanned.
- done  out  1  one-cycle pulse after the last bit has been consumed.
- led  out  1  sticky "pattern found" flag for the current/last run.
- match_cnt  out  CNT_W  number of hits in the current/last run, saturating at 2^CNT_W-1.
- first_pos  out  POS_W  bit index (0 = MSB) of the final bit of the first hit; valid only when led=1.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Any edge with button=1, in any state:
  - shreg←switch, bitcnt←0, window←0, fill←0, led←0, match_cnt←0, first_pos←0, state←RUN.
  - A press during RUN aborts the current run and restarts cleanly.
- Each RUN edge with button=0:
  - b = shreg[DATA_W-1]; shreg shifts left.
  - window←{window[PAT_W-2:0], b} (for PAT_W=1, window←b).
  - fill←min(fill+1, PAT_W).
- Hit condition: the new window equals PATTERN and (fill+1) ≥ PAT_W. On a hit:
  - led←1.
  - match_cnt←match_cnt+1, held at all-ones once saturated.
  - On the first hit of the run only, first_pos←bitcnt.
  - If OVERLAP=0, fill←0 (window contents are kept but not matchable until PAT_W new bits arrive).
- Run end: when bitcnt = DATA_W-1 → state←IDLE, done←1 for that one cycle. Otherwise bitcnt←bitcnt+1.
- In IDLE, led, match_cnt and first_pos hold until the next button press or reset.
- rst during any state: every register returns to its reset value immediately; no done pulse is produced.

## Timing
- Reset values: busy=0, done=0, led=0, match_cnt=0, first_pos=0, state=IDLE.
- Count the button edge as edge 0. The bit with index i is consumed at edge i+1.
- The last bit is consumed at edge DATA_W. done=1 after edge DATA_W, for exactly one cycle.
- busy=1 from after edge 0 until after edge DATA_W, so busy and done never overlap.
- Hit results (led, match_cnt, first_pos) update in the same edge that consumes the final pattern bit, so they are visible 1 cycle after that bit is clocked in.
- switch is ignored except on button edges. Its value may change freely during RUN.
- Minimum restart interval: 1 cycle. Back-to-back button pulses each restart the run.

## Structure
- Shared package seq_detect_pkg: state enum {IDLE, RUN}, default parameter constants (DATA_W, PAT_W, PATTERN), and a saturating-increment function.
- One sub-module, seq_window_matcher: holds window and fill, and takes the OVERLAP and PATTERN parameters. Inputs are bit, shift-enable and clear; output is a one-cycle hit. The top level owns the FSM, shreg, bitcnt and the result registers.

## Test plan
- Defaults, OVERLAP=1, switch=8'b10010010, button at edge 0 → hits at bit indices 4 and 7; led=1 after edge 5; match_cnt=2; first_pos=4; done pulse after edge 8.
- Same stimulus with OVERLAP=0 → match_cnt=1, first_pos=4, led=1. Only 3 bits remain after the first hit, so there is no second hit.
- switch=8'h00 → led=0, match_cnt=0, done after edge 8, busy high for exactly 8 cycles.
- PAT_W=1, PATTERN=1'b1, CNT_W=2, switch=8'hFF → match_cnt saturates at 3, first_pos=0, led=1.
- Restart: button with 8'h00 at edge 0, then button with 8'b10010000 at edge 3 → no done at edge 8; done after edge 11; match_cnt=1; first_pos=4.
- Reset mid-run: assert rst at edge 4 of a run with 8'b10010010 → all outputs 0 immediately, no done pulse. A subsequent button press runs normally and returns match_cnt=2.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// Shared types, default constants and helpers for the serial pattern detector.
package seq_detect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int         DEF_DATA_W  = 8;
    localparam int         DEF_PAT_W   = 5;
    localparam logic [4:0] DEF_PATTERN = 5'b10010;

    // Increment v, but hold once it reaches the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] max_v;
        max_v = (33'd1 << w) - 33'd1;
        if ({1'b0, v} >= max_v) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Start/word inputs and result outputs of the serial pattern detector.
//
// Handshake: button is a one-cycle start strobe with no back-pressure; the
// detector always accepts it and samples switch on that same edge. busy
// covers the scan, done pulses for one cycle after the last bit, and the
// result fields (led, match_cnt, first_pos) hold until the next start.
interface seq_detect_param_if
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 4,
    parameter int POS_W  = $clog2(DATA_W)
);
    logic              button;
    logic [DATA_W-1:0] switch;
    logic              busy;
    logic              done;
    logic              led;
    logic [CNT_W-1:0]  match_cnt;
    logic [POS_W-1:0]  first_pos;
    state_t            state_dbg;

    modport master (
        output button, switch,
        input  busy, done, led, match_cnt, first_pos, state_dbg
    );

    modport slave (
        input  button, switch,
        output busy, done, led, match_cnt, first_pos, state_dbg
    );
endinterface

// File: rtl/seq_detect_param_matcher.sv
// Sliding match window: shifts in one bit per enable and flags a hit when the
// window equals PATTERN and enough fresh bits have arrived.
module seq_window_matcher
#(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
    parameter int               OVERLAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic shift_en,
    input  logic clear,
    output logic hit
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window_q, window_d, new_win;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Next window/fill and the hit flag for the bit being consumed this cycle.
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        hit      = 1'b0;
        // Truncating the concatenation drops the oldest bit; also covers PAT_W=1.
        new_win  = PAT_W'({window_q, bit_i});
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
        end else if (shift_en) begin
            window_d = new_win;
            hit      = (new_win == PATTERN) && ((int'(fill_q) + 1) >= PAT_W);
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + FILL_W'(1);
            end
            // Non-overlapping mode: the window must refill before the next hit.
            if (hit && (OVERLAP == 0)) begin
                fill_d = '0;
            end
        end
    end

    // Window and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end
endmodule

// File: rtl/seq_detect_param.sv
// Captures a word on button, scans it MSB-first through the window matcher and
// records whether, how often and where the pattern first completed.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               DATA_W  = DEF_DATA_W,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 4,
    parameter int               POS_W   = $clog2(DATA_W)
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [POS_W-1:0]  bitcnt_q, bitcnt_d;
    logic              led_q, led_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0]  fpos_q, fpos_d;
    logic              done_q, done_d;
    logic              shift_en, clear, hit;

    seq_window_matcher #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .bit_i    (shreg_q[DATA_W-1]),
        .shift_en (shift_en),
        .clear    (clear),
        .hit      (hit)
    );

    // FSM next state, shifter, bit counter and result updates.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        led_d    = led_q;
        cnt_d    = cnt_q;
        fpos_d   = fpos_q;
        done_d   = 1'b0;
        shift_en = 1'b0;
        clear    = 1'b0;
        // A start press wins in every state, so it also aborts a run in progress.
        if (bus.button) begin
            shreg_d  = bus.switch;
            bitcnt_d = '0;
            led_d    = 1'b0;
            cnt_d    = '0;
            fpos_d   = '0;
            clear    = 1'b1;
            state_d  = RUN;
        end else if (state_q == RUN) begin
            shift_en = 1'b1;
            shreg_d  = shreg_q << 1;
            if (hit) begin
                led_d = 1'b1;
                cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
                if (!led_q) begin
                    fpos_d = bitcnt_q;
                end
            end
            if (bitcnt_q == POS_W'(DATA_W - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + POS_W'(1);
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            led_q    <= 1'b0;
            cnt_q    <= '0;
            fpos_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            fpos_q   <= fpos_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.led       = led_q;
    assign bus.match_cnt = cnt_q;
    assign bus.first_pos = fpos_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven with the same words.
module tb_seq_detect_param;
    import seq_detect_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic [7:0] switch = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.DATA_W(8), .CNT_W(4)) if_ov ();
    seq_detect_param_if #(.DATA_W(8), .CNT_W(4)) if_nov ();
    seq_detect_param_if #(.DATA_W(8), .CNT_W(2)) if_p1 ();

    assign if_ov.button  = button;
    assign if_ov.switch  = switch;
    assign if_nov.button = button;
    assign if_nov.switch = switch;
    assign if_p1.button  = button;
    assign if_p1.switch  = switch;

    seq_detect_param #(.DATA_W(8), .PAT_W(5), .PATTERN(5'b10010), .OVERLAP(1), .CNT_W(4))
        u_ov (.clk(clk), .rst(rst), .bus(if_ov));
    seq_detect_param #(.DATA_W(8), .PAT_W(5), .PATTERN(5'b10010), .OVERLAP(0), .CNT_W(4))
        u_nov (.clk(clk), .rst(rst), .bus(if_nov));
    seq_detect_param #(.DATA_W(8), .PAT_W(1), .PATTERN(1'b1), .OVERLAP(1), .CNT_W(2))
        u_p1 (.clk(clk), .rst(rst), .bus(if_p1));

    // Results after the first nbits bits of w, scanned MSB first.
    function automatic void model(input logic [7:0] w, input int pat_w, input int pat,
                                  input int overlap, input int cnt_w, input int nbits,
                                  output int led, output int cnt, output int fp);
        int last;
        bit ok;
        last = -1000;
        led  = 0;
        cnt  = 0;
        fp   = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i >= pat_w - 1) begin
                ok = 1'b1;
                for (int j = 0; j < pat_w; j++) begin
                    if (w[7 - (i - pat_w + 1 + j)] != pat[pat_w - 1 - j]) ok = 1'b0;
                end
                if (ok && (overlap != 0 || (i - last) >= pat_w)) begin
                    if (led == 0) fp = i;
                    led = 1;
                    if (cnt < (1 << cnt_w) - 1) cnt++;
                    last = i;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k = edges since the start press; k=9 means one cycle after the done pulse.
    task automatic check_all(input int k, input logic [7:0] w);
        int nb, led, cnt, fp;
        nb = (k > 8) ? 8 : k;
        chk("ov_busy", 32'(if_ov.busy), 32'(k < 8));
        chk("ov_done", 32'(if_ov.done), 32'(k == 8));
        chk("nov_busy", 32'(if_nov.busy), 32'(k < 8));
        chk("p1_done", 32'(if_p1.done), 32'(k == 8));
        model(w, 5, 5'b10010, 1, 4, nb, led, cnt, fp);
        chk("ov_led", 32'(if_ov.led), 32'(led));
        chk("ov_cnt", 32'(if_ov.match_cnt), 32'(cnt));
        chk("ov_fpos", 32'(if_ov.first_pos), 32'(fp));
        model(w, 5, 5'b10010, 0, 4, nb, led, cnt, fp);
        chk("nov_led", 32'(if_nov.led), 32'(led));
        chk("nov_cnt", 32'(if_nov.match_cnt), 32'(cnt));
        chk("nov_fpos", 32'(if_nov.first_pos), 32'(fp));
        model(w, 1, 1, 1, 2, nb, led, cnt, fp);
        chk("p1_led", 32'(if_p1.led), 32'(led));
        chk("p1_cnt", 32'(if_p1.match_cnt), 32'(cnt));
        chk("p1_fpos", 32'(if_p1.first_pos), 32'(fp));
    endtask

    // Called at a falling edge; presses start, then checks n consumed bits.
    task automatic run_bits(input logic [7:0] w, input int n);
        button = 1'b1;
        switch = w;
        @(negedge clk);
        button = 1'b0;
        switch = 8'($urandom);
        check_all(0, w);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            switch = 8'($urandom);
            check_all(k, w);
        end
        if (n == 8) begin
            @(negedge clk);
            check_all(9, w);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ov_busy"}, 32'(if_ov.busy), 32'd0);
        chk({tag, "_ov_done"}, 32'(if_ov.done), 32'd0);
        chk({tag, "_ov_led"}, 32'(if_ov.led), 32'd0);
        chk({tag, "_ov_cnt"}, 32'(if_ov.match_cnt), 32'd0);
        chk({tag, "_ov_fpos"}, 32'(if_ov.first_pos), 32'd0);
        chk({tag, "_ov_state"}, 32'(if_ov.state_dbg), 32'(IDLE));
        chk({tag, "_nov_cnt"}, 32'(if_nov.match_cnt), 32'd0);
        chk({tag, "_p1_cnt"}, 32'(if_p1.match_cnt), 32'd0);
        chk({tag, "_p1_done"}, 32'(if_p1.done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        int n;

        // Reset state.
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Two overlapping hits at bits 4 and 7; one hit without overlap.
        run_bits(8'b10010010, 8);
        chk("tp_ov_cnt", 32'(if_ov.match_cnt), 32'd2);
        chk("tp_ov_fpos", 32'(if_ov.first_pos), 32'd4);
        chk("tp_nov_cnt", 32'(if_nov.match_cnt), 32'd1);

        // No pattern at all; busy for exactly 8 cycles is covered per cycle.
        run_bits(8'h00, 8);
        chk("tp_zero_led", 32'(if_ov.led), 32'd0);

        // Saturating counter with the single-bit pattern.
        run_bits(8'hFF, 8);
        chk("tp_p1_cnt", 32'(if_p1.match_cnt), 32'd3);

        // Restart at edge 3 aborts the first run; done only after edge 11.
        run_bits(8'h00, 2);
        run_bits(8'b10010000, 8);
        chk("tp_rst_cnt", 32'(if_ov.match_cnt), 32'd1);
        chk("tp_rst_fpos", 32'(if_ov.first_pos), 32'd4);

        // Back-to-back presses.
        run_bits(8'hA5, 0);
        run_bits(8'b10010010, 8);

        // Asynchronous reset in the middle of a run.
        run_bits(8'b10010010, 3);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("postrst");
        @(negedge clk);
        check_zero("postrst2");
        run_bits(8'b10010010, 8);
        chk("tp_after_rst_cnt", 32'(if_ov.match_cnt), 32'd2);

        // Random words, random aborts and idle gaps with held results.
        for (int r = 0; r < 40; r++) begin
            w = 8'($urandom);
            if (r[0]) w = {3'($urandom), 5'b10010} ^ (8'($urandom) & 8'h03);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8;
            run_bits(w, n);
            if (n == 8) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    switch = 8'($urandom);
                    check_all(9, w);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
